// File: rtl/instr_encoder.sv
// Descriptor-to-MIPS-word encoder that streams encoded words into a 1024-word instruction memory.
// Optional macro CUSTOM_BRANCH_EN turns op_sel 24-30 into SPECIAL2-style custom compare/branch words.
module instr_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  op_sel,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic        imem_we,
    output logic [9:0]  imem_addr,
    output logic [31:0] imem_wdata,
    output logic [10:0] word_count,
    output logic        full,
    output logic        err
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_FULL = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t      state_q;
    logic [9:0]  ptr_q, ptr_d;
    logic [10:0] word_count_q, word_count_d;
    logic        imem_we_q;
    logic [9:0]  imem_addr_q;
    logic [31:0] imem_wdata_q;
    logic        full_q;
    logic        err_q;

    logic        enc_legal;
    logic [31:0] enc_word;
    logic        accept;

    function automatic logic [31:0] r_type(input logic [4:0] s, input logic [4:0] t,
                                           input logic [4:0] d, input logic [4:0] sh,
                                           input logic [5:0] fn);
        return {6'b000000, s, t, d, sh, fn};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] opc, input logic [4:0] s,
                                           input logic [4:0] t, input logic [15:0] im);
        return {opc, s, t, im};
    endfunction

    always_comb begin
        enc_legal = 1'b1;
        enc_word  = 32'h0;
        case (op_sel)
            5'd0:  enc_word = r_type(rs, rt, rd, shamt, 6'b100000);
            5'd1:  enc_word = r_type(rs, rt, rd, shamt, 6'b100010);
            5'd2:  enc_word = r_type(rs, rt, rd, shamt, 6'b100001);
            5'd3:  enc_word = r_type(rs, rt, rd, shamt, 6'b100011);
            5'd4:  enc_word = r_type(rs, rt, rd, shamt, 6'b100100);
            5'd5:  enc_word = r_type(rs, rt, rd, shamt, 6'b100101);
            5'd6:  enc_word = r_type(rs, rt, rd, shamt, 6'b100110);
            5'd7:  enc_word = r_type(rs, rt, rd, shamt, 6'b000000);
            5'd8:  enc_word = r_type(rs, rt, rd, shamt, 6'b000010);
            5'd9:  enc_word = r_type(rs, rt, rd, shamt, 6'b000011);
            5'd10: enc_word = r_type(rs, rt, rd, shamt, 6'b101010);
            5'd11: enc_word = r_type(rs, 5'd0, 5'd0, 5'd0, 6'b001000);
            5'd12: enc_word = i_type(6'b001000, rs, rt, imm);
            5'd13: enc_word = i_type(6'b001001, rs, rt, imm);
            5'd14: enc_word = i_type(6'b001100, rs, rt, imm);
            5'd15: enc_word = i_type(6'b001101, rs, rt, imm);
            5'd16: enc_word = i_type(6'b001110, rs, rt, imm);
            5'd17: enc_word = i_type(6'b001111, 5'd0, rt, imm);
            5'd18: enc_word = i_type(6'b100011, rs, rt, imm);
            5'd19: enc_word = i_type(6'b101011, rs, rt, imm);
            5'd20: enc_word = i_type(6'b000100, rs, rt, imm);
            5'd21: enc_word = i_type(6'b000101, rs, rt, imm);
            5'd22: enc_word = {6'b000010, target};
            5'd23: enc_word = {6'b000011, target};
`ifdef CUSTOM_BRANCH_EN
            5'd24: enc_word = {6'b011111, rs, rt, rd, 5'b00000, 6'b010001};
            5'd25: enc_word = {6'b011111, rs, rt, rd, 5'b00000, 6'b010010};
            5'd26: enc_word = {6'b011111, rs, rt, rd, 5'b00000, 6'b010011};
            5'd27: enc_word = {6'b011111, rs, rt, rd, 5'b00000, 6'b010100};
            5'd28: enc_word = {6'b011111, rs, rt, rd, 5'b00000, 6'b010101};
            5'd29: enc_word = {6'b011111, rs, rt, rd, 5'b00000, 6'b010110};
            5'd30: enc_word = {6'b011111, rs, rt, rd, 5'b00000, 6'b011000};
`endif
            default: enc_legal = 1'b0;
        endcase
    end

    // rst_n gates ready so nothing is offered as accepted while the block is held in reset
    assign in_ready     = rst_n & (state_q == S_RUN) & ~clear;
    assign accept       = in_valid & in_ready;
    assign ptr_d        = ptr_q + 10'd1;
    assign word_count_d = word_count_q + 11'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_RUN;
            ptr_q        <= 10'd0;
            word_count_q <= 11'd0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= 10'd0;
            imem_wdata_q <= 32'h0;
            full_q       <= 1'b0;
            err_q        <= 1'b0;
        end else if (clear) begin
            state_q      <= S_RUN;
            ptr_q        <= 10'd0;
            word_count_q <= 11'd0;
            imem_we_q    <= 1'b0;
            full_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            imem_we_q <= 1'b0;
            if (accept) begin
                if (enc_legal) begin
                    imem_we_q    <= 1'b1;
                    imem_addr_q  <= ptr_q;
                    imem_wdata_q <= enc_word;
                    word_count_q <= word_count_d;
                    // last slot: stop at 1023 rather than wrapping over word 0
                    if (ptr_q == 10'd1023) begin
                        state_q <= S_FULL;
                        full_q  <= 1'b1;
                    end else begin
                        ptr_q <= ptr_d;
                    end
                end else begin
                    state_q <= S_ERR;
                    err_q   <= 1'b1;
                end
            end
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign word_count = word_count_q;
    assign full       = full_q;
    assign err        = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: vector table of encodings plus fill/error/clear/reset sequences.
// Expected writes go to a scoreboard queue at drive time and are popped by a negedge write monitor.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  op_sel = '0, rs = '0, rt = '0, rd = '0, shamt = '0;
    logic [15:0] imm = '0;
    logic [25:0] target = '0;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [10:0] word_count;
    logic        full, err;

    instr_encoder dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm), .target(target),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .word_count(word_count), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op, rs, rt, rd, sh;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic        legal;
        logic [31:0] word;
    } vec_t;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_ptr = 0, m_count = 0, m_state = 0; // 0 run, 1 full, 2 err

`ifdef CUSTOM_BRANCH_EN
    localparam bit CUSTOM = 1'b1;
`else
    localparam bit CUSTOM = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int op, input int s, input int t, input int d, input int sh,
                                input int im, input int tg, input bit legal, input logic [31:0] w);
        vec_t v;
        v.op = 5'(op); v.rs = 5'(s); v.rt = 5'(t); v.rd = 5'(d); v.sh = 5'(sh);
        v.imm = 16'(im); v.tgt = 26'(tg); v.legal = legal; v.word = w;
        return v;
    endfunction

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got write addr=%0d data=%h, want no write (t=%0t)",
                         imem_addr, imem_wdata, $time);
            end else begin
                mon_e = sb.pop_front();
                chk("write_addr", 32'(imem_addr), 32'(mon_e.addr));
                chk("write_data", imem_wdata, mon_e.data);
            end
        end
    end

    task automatic send(input vec_t v);
        @(negedge clk);
        op_sel = v.op; rs = v.rs; rt = v.rt; rd = v.rd; shamt = v.sh;
        imm = v.imm; target = v.tgt; in_valid = 1'b1;
        #1 chk("in_ready", 32'(in_ready), 32'(m_state == 0));
        if (m_state == 0) begin
            if (v.legal) begin
                sb.push_back('{addr: 10'(m_ptr), data: v.word});
                m_count++;
                if (m_ptr == 1023) m_state = 1;
                else m_ptr++;
            end else begin
                m_state = 2;
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1; in_valid = 1'b1; op_sel = 5'd0;
        #1 chk("clear_blocks_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 clear = 1'b0; in_valid = 1'b0;
        m_ptr = 0; m_count = 0; m_state = 0;
        #1;
        chk("clear_word_count", 32'(word_count), 32'd0);
        chk("clear_full", 32'(full), 32'd0);
        chk("clear_err", 32'(err), 32'd0);
        chk("clear_we", 32'(imem_we), 32'd0);
        chk("clear_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want run completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs.push_back(mk(0,  1, 2, 3, 0, 0, 0, 1, 32'h00221820));
        vecs.push_back(mk(1,  4, 5, 6, 0, 0, 0, 1, 32'h00853022));
        vecs.push_back(mk(2,  1, 1, 1, 0, 0, 0, 1, 32'h00210821));
        vecs.push_back(mk(4,  2, 3, 4, 0, 0, 0, 1, 32'h00432024));
        vecs.push_back(mk(6,  7, 8, 9, 0, 0, 0, 1, 32'h00E84826));
        vecs.push_back(mk(7,  0, 9, 10, 3, 0, 0, 1, 32'h000950C0));
        vecs.push_back(mk(9,  0, 1, 2, 31, 0, 0, 1, 32'h000117C3));
        vecs.push_back(mk(10, 2, 3, 4, 0, 0, 0, 1, 32'h0043202A));
        vecs.push_back(mk(11, 31, 5, 6, 7, 0, 0, 1, 32'h03E00008));
        vecs.push_back(mk(12, 1, 2, 9, 9, 16'hFFFF, 0, 1, 32'h2022FFFF));
        vecs.push_back(mk(15, 3, 4, 0, 0, 16'h00FF, 0, 1, 32'h346400FF));
        vecs.push_back(mk(17, 5, 7, 0, 0, 16'h1234, 0, 1, 32'h3C071234));
        vecs.push_back(mk(19, 29, 31, 0, 0, 16'h0008, 0, 1, 32'hAFBF0008));
        vecs.push_back(mk(21, 1, 0, 0, 0, 16'hFFFE, 0, 1, 32'h1420FFFE));
        vecs.push_back(mk(23, 3, 3, 3, 3, 0, 26'h3FFFFFF, 1, 32'h0FFFFFFF));
        vecs.push_back(mk(30, 3, 4, 5, 0, 0, 0, CUSTOM, 32'h7C642818));

        // reset values while rst_n is held low
        #1;
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        #11 rst_n = 1'b1;
        #1 chk("ready_after_release", 32'(in_ready), 32'd1);

        // first add
        send(mk(0, 1, 2, 3, 0, 0, 0, 1, 32'h00221820));
        chk("add_word_count", 32'(word_count), 32'd1);
        chk("add_we_next_cycle", 32'(imem_we), 32'd1);

        // back-to-back lw then j
        do_clear();
        send(mk(18, 29, 8, 0, 0, 4, 0, 1, 32'h8FA80004));
        send(mk(22, 0, 0, 0, 0, 0, 26'h10, 1, 32'h08000010));
        chk("b2b_second_we", 32'(imem_we), 32'd1);
        drain();
        chk("b2b_word_count", 32'(word_count), 32'd2);

        // encoding table as one back-to-back stream
        do_clear();
        for (int i = 0; i < vecs.size(); i++) send(vecs[i]);
        drain();
        chk("table_word_count", 32'(word_count), 32'(m_count));
        chk("table_err", 32'(err), 32'(m_state == 2));

        // illegal op after three words
        do_clear();
        for (int i = 0; i < 3; i++) send(mk(0, i, i, i, 0, 0, 0, 1, {6'b0, 5'(i), 5'(i), 5'(i), 5'b0, 6'b100000}));
        send(mk(31, 1, 2, 3, 0, 0, 0, 0, 32'h0));
        drain();
        chk("illegal_err", 32'(err), 32'd1);
        chk("illegal_word_count", 32'(word_count), 32'd3);
        chk("illegal_ready", 32'(in_ready), 32'd0);
        send(mk(0, 1, 2, 3, 0, 0, 0, 1, 32'h00221820));
        drain();
        chk("err_sticky", 32'(err), 32'd1);

        // custom branch
        do_clear();
        send(mk(24, 1, 2, 0, 0, 0, 0, CUSTOM, 32'h7C220011));
        drain();
        chk("bgt_err", 32'(err), 32'(!CUSTOM));
        chk("bgt_word_count", 32'(word_count), 32'(CUSTOM));

        // fill all 1024 slots
        do_clear();
        for (int i = 0; i < 1024; i++)
            send(mk(0, i % 32, (i / 32) % 32, 31 - (i % 32), 0, 0, 0, 1,
                    {6'b0, 5'(i % 32), 5'((i / 32) % 32), 5'(31 - (i % 32)), 5'b0, 6'b100000}));
        drain();
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_word_count", 32'(word_count), 32'd1024);
        chk("fill_ready", 32'(in_ready), 32'd0);
        chk("fill_last_addr", 32'(imem_addr), 32'd1023);
        send(mk(0, 1, 2, 3, 0, 0, 0, 1, 32'h00221820));
        drain();
        chk("overflow_word_count", 32'(word_count), 32'd1024);
        do_clear();
        send(mk(0, 1, 2, 3, 0, 0, 0, 1, 32'h00221820));
        drain();

        // reset aborting a pending write
        @(negedge clk);
        op_sel = 5'd0; rs = 5'd4; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("pending_we", 32'(imem_we), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_we", 32'(imem_we), 32'd0);
        chk("abort_word_count", 32'(word_count), 32'd0);
        chk("abort_ready", 32'(in_ready), 32'd0);
        chk("abort_wdata", imem_wdata, 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        m_ptr = 0; m_count = 0; m_state = 0;
        #1 chk("abort_ready_release", 32'(in_ready), 32'd1);

        // reset pulsed across the accept edge
        @(negedge clk);
        op_sel = 5'd0; in_valid = 1'b1;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1; in_valid = 1'b0;
        #1;
        chk("rst_accept_we", 32'(imem_we), 32'd0);
        chk("rst_accept_word_count", 32'(word_count), 32'd0);
        chk("rst_accept_ready", 32'(in_ready), 32'd1);
        send(mk(0, 1, 2, 3, 0, 0, 0, 1, 32'h00221820));
        drain();

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
